// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types for the sequential execution-stage ALU.
//   alu_op_e    : 4-bit operation codes as produced by the ALU controller
//   alu_state_e : control states of alu_seq_unit
//   is_shift_op : true for the iterative (one bit per cycle) operations
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_BGE  = 4'b0101,
    OP_BNE  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_RSVD = 4'b1011,
    OP_SRL  = 4'b1100,
    OP_BLT  = 4'b1101,
    OP_SLT  = 4'b1110,
    OP_JALR = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb
// Purely combinational single-cycle part of the ALU: add/sub/logic,
// compares, branch conditions, LUI and JALR. Shift codes and the
// reserved code produce zero here; the top handles shifts itself.
// Ports:
//   i_op     : operation code
//   i_a/i_b  : operands
//   o_result : single-cycle result
//   o_cond   : branch-taken / compare flag
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cond
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic             w_eq;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = $signed(i_a) < $signed(i_b);
  assign w_eq   = (i_a == i_b);

  // Compare-type ops return their flag both in bit 0 of the result and on o_cond.
  always_comb begin
    o_result = '0;
    o_cond   = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = w_sum;
      OP_SUB:  o_result = w_diff;
      OP_LUI:  o_result = i_b;
      OP_JALR: o_result = w_sum & {{(WIDTH-1){1'b1}}, 1'b0};
      OP_BEQ:  o_cond   = w_eq;
      OP_BNE:  o_cond   = ~w_eq;
      OP_BLT:  o_cond   = w_lt;
      OP_BGE:  o_cond   = ~w_lt;
      OP_SLT:  o_cond   = w_lt;
      default: o_result = '0;
    endcase
    if (o_cond) o_result = {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit
// Execution-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after accept; shifts iterate one
// bit per cycle through a working register and a down-counter.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   in_valid / in_ready   : request handshake
//   Operation, SrcA, SrcB : op code and operands (shift amount in SrcB[SHW-1:0])
//   out_valid / out_ready : result handshake
//   ALUResult, Cond       : registered result and branch/compare flag
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Cond
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  alu_state_e       r_state;
  alu_state_e       w_next_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_count;
  alu_op_e          r_shift_op;
  logic [WIDTH-1:0] r_result;
  logic             r_cond;

  alu_op_e          w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_accept;
  logic             w_start_shift;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_comb_result;
  logic             w_comb_cond;
  logic [WIDTH-1:0] w_accept_result;
  logic             w_accept_cond;

  assign w_op          = alu_op_e'(Operation);
  assign w_amt         = SrcB[SHW-1:0];
  assign in_ready      = reset_n & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept      = in_valid & in_ready;
  assign w_start_shift = w_accept & is_shift_op(w_op) & (w_amt != '0);
  assign out_valid     = (r_state == DONE);
  assign ALUResult     = r_result;
  assign Cond          = r_cond;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .i_op     (w_op),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_result (w_comb_result),
    .o_cond   (w_comb_cond)
  );

  // A shift by zero is just a pass-through of A and never enters SHIFT.
  assign w_accept_result = is_shift_op(w_op) ? SrcA : w_comb_result;
  assign w_accept_cond   = is_shift_op(w_op) ? 1'b0 : w_comb_cond;

  always_comb begin
    w_shifted = r_work;
    case (r_shift_op)
      OP_SLL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = r_work;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // A new accept out of DONE takes priority over simply draining to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (r_count == CNT_ONE) w_next_state = DONE;
      end
      DONE: begin
        if (w_accept)       w_next_state = w_start_shift ? SHIFT : DONE;
        else if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The counter holds the number of shifts still to do; the cycle that
  // sees it at 1 performs the final shift and lands the result directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work     <= '0;
      r_count    <= '0;
      r_shift_op <= OP_AND;
      r_result   <= '0;
      r_cond     <= 1'b0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_work     <= SrcA;
        r_count    <= w_amt;
        r_shift_op <= w_op;
      end else begin
        r_result <= w_accept_result;
        r_cond   <= w_accept_cond;
      end
    end else if (r_state == SHIFT) begin
      r_work  <= w_shifted;
      r_count <= r_count - CNT_ONE;
      if (r_count == CNT_ONE) begin
        r_result <= w_shifted;
        r_cond   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit
// Directed self-checking bench for alu_seq_unit (WIDTH=32). Expected
// results are queued when a request is driven and popped when the unit
// presents a result.
module tb_alu_seq_unit;

  typedef struct packed {
    logic [31:0] result;
    logic        cond;
  } expect_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Cond;

  expect_t scoreQ[$];
  int      checks = 0;
  int      errors = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Cond      (Cond)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something escapes the per-wait bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, queue its expected result,
  // then scramble the inputs to prove they were captured at accept.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input logic expCond);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    #1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    scoreQ.push_back(expect_t'{result: expRes, cond: expCond});
    step();
    in_valid  = 1'b0;
    Operation = 4'h4;
    SrcA      = $urandom;
    SrcB      = $urandom;
  endtask

  // Wait (bounded) for out_valid, checking cycles taken and that the
  // unit never offered in_ready while busy, then compare with the queue head.
  task automatic waitResult(input string tag, input int expLatency);
    int      n = 0;
    bit      readyLeak = 1'b0;
    expect_t exp;
    while (!out_valid && n < 200) begin
      if (in_ready) readyLeak = 1'b1;
      step();
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(expLatency));
    checkOutput({tag, " in_ready busy"}, 32'(readyLeak), 32'd0);
    checkOutput({tag, " scoreboard depth"}, 32'(scoreQ.size()), 32'd1);
    if (scoreQ.size() != 0) begin
      exp = scoreQ.pop_front();
      checkOutput({tag, " result"}, ALUResult, exp.result);
      checkOutput({tag, " cond"}, 32'(Cond), 32'(exp.cond));
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic expCond, input int expLatency);
    applyStimulus(tag, op, a, b, expRes, expCond);
    waitResult(tag, expLatency);
    step();
    checkOutput({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Operation = 4'h0;
    SrcA      = '0;
    SrcB      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", ALUResult, 32'd0);
    checkOutput("reset cond", 32'(Cond), 32'd0);
    reset_n = 1'b1;
    step();
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    runOp("ADD wrap", 4'b0100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 0);
    runOp("SUB 0-1", 4'b0010, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
    runOp("BLT -1<1", 4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 0);
    runOp("BGE -1>=1", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    runOp("BEQ 5,5", 4'b1000, 32'd5, 32'd5, 32'd1, 1'b1, 0);
    runOp("BNE 5,5", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 0);
    runOp("SLT -1<1", 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 0);
    runOp("AND", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 0);
    runOp("LUI", 4'b1010, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 0);

    runOp("SRA 31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31);
    runOp("SRL 31", 4'b1100, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 31);
    runOp("SLL 0", 4'b1001, 32'd1, 32'd0, 32'd1, 1'b0, 0);
    runOp("SLL 4", 4'b1001, 32'd3, 32'd4, 32'h30, 1'b0, 4);

    // Backpressure: result must hold while out_ready is low and no request gets in.
    out_ready = 1'b0;
    applyStimulus("XOR", 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      Operation = 4'b0000;
      SrcA      = $urandom;
      SrcB      = $urandom;
      #1;
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold result", ALUResult, 32'h0000_FF00);
      step();
    end
    waitResult("XOR held", 0);
    Operation = 4'b0011;
    SrcA      = 32'd1;
    SrcB      = 32'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("OR same-cycle in_ready", 32'(in_ready), 32'd1);
    scoreQ.push_back(expect_t'{result: 32'd3, cond: 1'b0});
    step();
    in_valid = 1'b0;
    waitResult("OR no bubble", 0);
    step();

    // Reset in the middle of a long shift aborts it without a result.
    applyStimulus("SLL 20", 4'b1001, 32'd1, 32'd20, 32'h0010_0000, 1'b0);
    repeat (6) step();
    checkOutput("mid-shift busy", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    scoreQ.delete();
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort result", ALUResult, 32'd0);
    checkOutput("abort cond", 32'(Cond), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    checkOutput("rerelease in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("aborted no result", 32'(out_valid), 32'd0);

    runOp("JALR", 4'b1111, 32'h0000_1001, 32'd2, 32'h0000_1002, 1'b0, 0);
    runOp("RSVD", 4'b1011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Execution-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a result and a branch condition. Arithmetic, logic and compare operations take one cycle. Shifts are iterative, one bit per cycle, to save area. Both sides use valid/ready handshakes, so the pipeline stalls while a shift is in progress.

## Interface
- `WIDTH`, default 32: operand and result width; shift amount width is `SHW = $clog2(WIDTH)`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request this cycle.
- `Operation` in 4: operation code (encoding below).
- `SrcA` in WIDTH: operand A.
- `SrcB` in WIDTH: operand B (shift amount in `SrcB[SHW-1:0]`).
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: consumer accepts the result.
- `ALUResult` out WIDTH: registered result.
- `Cond` out 1: registered branch-taken / compare flag.

## Operation
- Operation encoding:
  - `0000` AND, `0001` XOR, `0010` SUB, `0011` OR, `0100` ADD.
  - `0101` BGE (signed A≥B), `0110` BNE, `0111` SRA, `1000` BEQ, `1001` SLL.
  - `1010` LUI (pass B), `1011` reserved, `1100` SRL, `1101` BLT (signed A<B), `1110` SLT.
  - `1111` JALR: (A+B) with bit0 cleared.
- Branch codes (BEQ/BNE/BLT/BGE): `ALUResult` = {0…,cond}, `Cond` = cond.
- SLT: result = {0…,A<B signed}, `Cond` = the same bit.
- All other codes: `Cond` = 0.
- Reserved `1011`: result 0, `Cond` 0, single cycle.
- ADD/SUB/JALR wrap modulo 2^WIDTH. No overflow flag.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept (`in_valid & in_ready`) of a non-shift op, or a shift with amount 0: compute and register the result, go to DONE.
  - IDLE, accept of a shift with amount N>0: load the working register with A, load the counter with N, go to SHIFT.
  - SHIFT: each cycle, shift the working register by 1 (SLL left with zero fill; SRL right with zero fill; SRA right with sign fill) and decrement the counter. When the counter reaches 1, that cycle's shift is the last: register the result and go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE, unless a new request is accepted in the same cycle; that request is handled as from IDLE.
- `in_ready` = `reset_n` & (state==IDLE | (state==DONE & `out_ready`)).
- Operands and `Operation` are captured at accept. Later input changes do not affect an operation in flight.
- While `out_valid` is high and `out_ready` is low, `ALUResult` and `Cond` hold stable.

## Timing
- Reset (async assert, any state including mid-shift):
  - State → IDLE; `out_valid`=0, `ALUResult`=0, `Cond`=0, counter=0.
  - `in_ready`=0 while `reset_n` is low, and 1 from the first cycle after deassertion.
  - The aborted operation produces no result.
- Non-shift latency: accepted at edge t, `out_valid` high after edge t+1.
- Shift by N>0: `out_valid` high after edge t+1+N. For WIDTH=32, the worst case is N=31, which gives 32 cycles.
- Back-to-back throughput for non-shift ops: one result per cycle while `out_ready` is held high.
- `in_ready` is 0 throughout SHIFT.

## Structure
- Package `alu_seq_pkg`:
  - Enum `alu_op_e` for the 16 Operation codes (shared with the ALU controller).
  - Enum `alu_state_e` {IDLE, SHIFT, DONE}.
- Sub-module `alu_seq_comb`: purely combinational single-cycle ops (add/sub/logic/compare/LUI/JALR), producing result and cond from A, B and op. The top holds the FSM, the shift register, the counter and the output register.
- Target size is 150–250 lines of RTL in total.

## Test plan
- ADD A=0x7FFFFFFF, B=1 → 0x80000000, `Cond`=0, `out_valid` one cycle after accept. SUB 0 − 1 → 0xFFFFFFFF.
- BLT A=0xFFFFFFFF (−1), B=1 → `Cond`=1, result 1. BGE with the same operands → `Cond`=0. BEQ 5,5 → 1. BNE 5,5 → 0.
- Shift cases:
  - SRA A=0x80000000, B=31 → 0xFFFFFFFF after 32 cycles, `in_ready`=0 throughout.
  - SRL with the same operands → 0x00000001.
  - SLL A=1, B=0 → 1 in a single cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after an XOR 0xF0F0^0x0FF0 → 0xFF00 held stable and no new accept. Then pulse `out_ready` together with a new `in_valid` OR 0x1|0x2 → the next result is 0x3 on the following cycle, with no bubble.
- Reset mid-shift: start SLL by 20, assert `reset_n` low at cycle 7 → outputs immediately 0, `out_valid`=0. After release, JALR A=0x1001, B=2 → 0x1002.
- Reserved code `1011` with any operands → result 0, `Cond` 0, one-cycle latency.
